univ_shift_reg: RTL and testbench

- Parametrised successor to the single-bit synchronous-store flip-flop: a WIDTH-bit register with eight operating modes (hold, load, shift, rotate, increment, decrement).
- Used as the storage and counting primitive in the Chapter 2 hierarchical designs, such as ripple and synchronous counters and serial links.
- State updates on the falling edge of clk, as in that family of blocks.
- Adds an enable, synchronous clear, serial in/out and status flags.

---
 rtl/univ_shift_reg.sv | 100 ++++++++++
 tb/tb_univ_shift_reg.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, load, shift, rotate, increment, decrement.
// State updates on the falling edge of clk; reset is asynchronous and active-low.
module univ_shift_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             co,
  output logic             zero
);

  localparam int unsigned WX = WIDTH + 1;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic             co_nxt;
  logic [WX-1:0]    sum;
  logic [WX-1:0]    diff;

  // Extended-width arithmetic so the top bit carries the wrap (carry or borrow).
  assign sum  = WX'(q) + WX'(1);
  assign diff = WX'(q) - WX'(1);

  // Next-state decode; unknown or X mode falls to the default (hold) branch.
  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    co_nxt   = co;
    if (en) begin
      sout_nxt = 1'b0;
      co_nxt   = 1'b0;
      if (clr) begin
        q_nxt = '0;
      end else begin
        case (mode)
          MODE_HOLD: q_nxt = q;
          MODE_LOAD: q_nxt = d;
          MODE_SHL: begin
            q_nxt    = {q[WIDTH-2:0], sin};
            sout_nxt = q[WIDTH-1];
          end
          MODE_SHR: begin
            q_nxt    = {sin, q[WIDTH-1:1]};
            sout_nxt = q[0];
          end
          MODE_ROL: begin
            q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
            sout_nxt = q[WIDTH-1];
          end
          MODE_ROR: begin
            q_nxt    = {q[0], q[WIDTH-1:1]};
            sout_nxt = q[0];
          end
          MODE_INC: begin
            q_nxt  = sum[WIDTH-1:0];
            co_nxt = sum[WIDTH];
          end
          MODE_DEC: begin
            q_nxt  = diff[WIDTH-1:0];
            co_nxt = diff[WIDTH];
          end
          default: q_nxt = q;
        endcase
      end
    end
  end

  // State register on the falling edge.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q    <= WIDTH'(RESET_VAL);
      sout <= 1'b0;
      co   <= 1'b0;
    end else begin
      q    <= q_nxt;
      sout <= sout_nxt;
      co   <= co_nxt;
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed plan steps, then random
// operations compared against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int unsigned W  = 4;
  localparam int unsigned M  = 16;
  localparam int unsigned RV = 4'hA;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
  localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, INC = 3'b110, DEC = 3'b111;

  logic         clk, reset, en, clr, sin;
  logic [2:0]   mode;
  logic [W-1:0] d, q;
  logic         sout, co, zero;

  int tests = 0;
  int fails = 0;
  int mq, ms, mc;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode),
    .d(d), .sin(sin), .q(q), .sout(sout), .co(co), .zero(zero)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(mq));
    chk({tag, ".sout"}, 32'(sout), 32'(ms));
    chk({tag, ".co"}, 32'(co), 32'(mc));
    chk({tag, ".zero"}, 32'(zero), 32'(mq == 0));
  endtask

  // Reference: register treated as an integer modulo 2^W.
  task automatic model_edge();
    int oq;
    oq = mq;
    if (!reset) begin
      mq = RV; ms = 0; mc = 0;
    end else if (en) begin
      ms = 0; mc = 0;
      if (clr) mq = 0;
      else if (!$isunknown(mode)) begin
        case (int'(mode))
          1: mq = int'(d);
          2: begin mq = (oq * 2 + int'(sin)) % M; ms = oq / (M / 2); end
          3: begin mq = oq / 2 + int'(sin) * (M / 2); ms = oq % 2; end
          4: begin mq = (oq * 2) % M + oq / (M / 2); ms = oq / (M / 2); end
          5: begin mq = oq / 2 + (oq % 2) * (M / 2); ms = oq % 2; end
          6: begin mq = (oq + 1) % M; mc = (oq == M - 1) ? 1 : 0; end
          7: begin mq = (oq + M - 1) % M; mc = (oq == 0) ? 1 : 0; end
          default: mq = oq;
        endcase
      end
    end
  endtask

  task automatic edge_step(input string tag);
    model_edge();
    @(negedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic op(input logic [2:0] m, input logic [W-1:0] dv, input logic s, input string tag);
    en = 1'b1; clr = 1'b0; mode = m; d = dv; sin = s;
    edge_step(tag);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; mode = HOLD; d = '0; sin = 1'b0;
    mq = RV; ms = 0; mc = 0;

    // Reset held while clock toggles
    repeat (2) @(negedge clk);
    #1;
    chk("rst.q", 32'(q), 32'h0000000A);
    chk("rst.sout", 32'(sout), 32'd0);
    chk("rst.co", 32'(co), 32'd0);
    chk("rst.zero", 32'(zero), 32'd0);
    reset = 1'b1;
    op(HOLD, 4'h0, 1'b0, "hold_after_rst");
    chk("hold_after_rst.const", 32'(q), 32'h0000000A);

    // Load then shift left
    op(LOAD, 4'b1001, 1'b0, "load1001");
    for (int i = 0; i < 4; i++) op(SHL, 4'h0, 1'b0, $sformatf("shl%0d", i));
    chk("shl.zero_const", 32'(zero), 32'd1);
    chk("shl.sout_const", 32'(sout), 32'd1);

    // Rotate right
    op(LOAD, 4'b0001, 1'b0, "load0001");
    for (int i = 0; i < 4; i++) op(ROR, 4'h0, 1'b0, $sformatf("ror%0d", i));
    chk("ror.q_const", 32'(q), 32'd1);

    // Count wrap both ways
    op(LOAD, 4'hE, 1'b0, "loadE");
    for (int i = 0; i < 3; i++) op(INC, 4'h0, 1'b0, $sformatf("inc%0d", i));
    for (int i = 0; i < 2; i++) op(DEC, 4'h0, 1'b0, $sformatf("dec%0d", i));
    chk("dec.borrow_const", 32'(co), 32'd1);

    // Enable low holds sticky sout/co
    en = 1'b0; mode = INC;
    for (int i = 0; i < 5; i++) edge_step($sformatf("en0_%0d", i));
    chk("en0.q_const", 32'(q), 32'h0000000F);

    // Clear beats mode, disabled clear does nothing
    en = 1'b1; clr = 1'b1; mode = LOAD; d = 4'h7;
    edge_step("clr_load");
    op(LOAD, 4'h5, 1'b0, "load5");
    en = 1'b0; clr = 1'b1;
    edge_step("clr_en0");

    // X mode behaves as hold
    en = 1'b1; clr = 1'b0; mode = 3'bxxx;
    edge_step("xmode");

    // Async reset between edges during counting
    op(INC, 4'h0, 1'b0, "inc_pre_rst");
    #2;
    reset = 1'b0;
    mq = RV; ms = 0; mc = 0;
    #1;
    check_all("async_rst");
    edge_step("rst_edge");
    reset = 1'b1;
    op(INC, 4'h0, 1'b0, "inc_post_rst");
    chk("inc_post_rst.const", 32'(q), 32'h0000000B);

    // Random operations with occasional asynchronous reset pulses
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 11) == 0);
      mode = 3'($urandom_range(0, 7));
      d    = W'($urandom_range(0, M - 1));
      sin  = 1'($urandom_range(0, 1));
      edge_step($sformatf("rnd%0d", i));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        mq = RV; ms = 0; mc = 0;
        #1;
        check_all($sformatf("rnd_rst%0d", i));
        reset = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
